semaforo_n: RTL and testbench
=============================

# semaforo_n

Parametrised traffic-light controller for N approaches sharing one intersection. It is the successor to the two-way `semaforo`. Only one approach is ever green. Each green is followed by yellow and then an all-red clearance. Per-way request buttons make the controller skip approaches nobody is waiting at, and a night-mode input switches the whole intersection to flashing yellow. It sits directly behind the button debouncers and drives the lamp decoders.

## Interface
- `N_WAYS`, 2: number of approaches, 2..8.
- `CNT_W`, 8: phase counter width.
- `T_VERDE`, 1: green duration, in cycles.
- `T_AMARELO`, 3: yellow duration, in cycles; also the flash half-period.
- `T_VERMELHO`, 2: all-red clearance duration, in cycles.
- All T_* values are in the range 1..2^CNT_W-1.
- `AW` (localparam) = max(1, $clog2(N_WAYS)).

Ports (clock and reset first):
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `bt` in N_WAYS: per-way request button, one bit per approach, sampled on the rising edge of `clk`.
- `noturno` in 1: night mode request (level).
- `luzes` out 3*N_WAYS: lamps for way i at [3i+2:3i], encoded as {vermelho, amarelo, verde}, one-hot or all-zero.
- `ativa` out AW: index of the way currently owning the phase.
- `pend` out N_WAYS: latched request vector.

## Operation
- States: VERDE, AMARELO, VERMELHO_TOTAL, PISCA.
- Reset values: state VERDE, `ativa`=0, counter=0, `pend`=0, flash phase=on.
- Counter behaviour:
  - Counts 0..T-1 within a phase.
  - The transition happens on the edge where counter==T-1.
  - The counter clears on every state change.
- Lamps are decoded from registered state only (Moore):
  - VERDE: way `ativa`=001, all others=100.
  - AMARELO: way `ativa`=010, all others=100.
  - VERMELHO_TOTAL: all ways=100.
  - PISCA: all ways=010 when the flash phase is on, 000 when off.
- Normal transitions:
  - VERDE → AMARELO after T_VERDE cycles.
  - AMARELO → VERMELHO_TOTAL after T_AMARELO cycles.
  - VERMELHO_TOTAL → VERDE after T_VERMELHO cycles, with the next way chosen as below.
- Next-way selection at the VERMELHO_TOTAL → VERDE edge:
  - Request set is `pend | bt`.
  - If the set is non-empty: pick the first requesting way scanning from `ativa`+1 mod N_WAYS. This may be `ativa` itself if it is the only requester.
  - If the set is empty: pick `ativa`+1 mod N_WAYS (plain round-robin).
- Request latch:
  - On each edge, `pend[j]` is set by `bt[j]`.
  - `pend[j]` is cleared on the edge that way j enters VERDE; clear wins over a simultaneous set.
  - `bt[ativa]` while in VERDE is ignored (not latched).
- Night mode:
  - `noturno`=1 in VERDE: go to AMARELO on the next edge, cutting green short.
  - `noturno`=1 in AMARELO: finish AMARELO, then go to PISCA instead of VERMELHO_TOTAL.
  - `noturno`=1 in VERMELHO_TOTAL: go to PISCA on the next edge.
- PISCA:
  - Flash phase toggles every T_AMARELO cycles, starting at on.
  - `pend` is held at 0 and `bt` is ignored.
  - `noturno`=0 in PISCA: go to VERMELHO_TOTAL on the next edge with `ativa` forced to N_WAYS-1. After clearance, the empty request set therefore selects way 0.
- Reset mid-phase: all state returns to the reset values immediately (asynchronously). Lamps show way 0 green while `rst` is high.

## Timing
- `luzes`, `ativa` and `pend` are registers or decodes of registers, so they change only after a rising edge of `clk` or an assertion of `rst`.
- Green-cycle period with no requests and no night mode: T_VERDE+T_AMARELO+T_VERMELHO cycles per way.
- Button-to-latch latency: 1 edge (`pend` updates on the sampling edge). A request pulse of one cycle is never lost.
- `noturno` takes effect within 1 cycle, except in AMARELO, where it waits for the remainder of the yellow phase. Exit from PISCA takes 1 cycle, followed by a full T_VERMELHO clearance.
- No combinational path from inputs to outputs.

## Test plan
- Defaults (N_WAYS=2, 1/3/2), `rst` high for 1 cycle, no buttons → way 0 = 001 for 1 cycle, 010 for 3, all-red for 2; way 1 green on cycle 7; the pattern repeats every 12 cycles.
- N_WAYS=4, request pulse on `bt[2]` while way 0 is green → `pend`=0100; after way 0's clearance, `ativa`=2 (way 1 skipped); `pend`=0000 on that edge.
- N_WAYS=4, `bt`=1010 pulsed together → served in order 1 then 3 (way 2 skipped), then round-robin to way 0.
- `noturno` raised mid-VERDE → AMARELO next cycle, full 3-cycle yellow, then all ways toggle 010/000 every 3 cycles; `bt` pulses leave `pend`=0. `noturno` dropped → 2 cycles all-red, then way 0 green.
- `rst` pulsed during AMARELO of way 1 → outputs return to way 0 green, `pend`=0, and timing restarts from cycle 0 after release.
- `bt[j]` held high continuously → way j is cleared on green entry and re-latched on the next edge (after its VERDE phase ends), so it is served again on its next turn.

Source files
------------

// File: rtl/semaforo_n.sv
`default_nettype none
// ============================================================================
// Module      : semaforo_n
// Description : N-way traffic-light controller with request skipping and
//               flashing-yellow night mode.
// Revision    : 1.0 - initial release
// ============================================================================
module semaforo_n #(
    parameter int N_WAYS     = 2,
    parameter int CNT_W      = 8,
    parameter int T_VERDE    = 1,
    parameter int T_AMARELO  = 3,
    parameter int T_VERMELHO = 2,
    localparam int AW        = (N_WAYS > 2) ? $clog2(N_WAYS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_WAYS-1:0]     bt,
    input  logic                  noturno,
    output logic [3*N_WAYS-1:0]   luzes,
    output logic [AW-1:0]         ativa,
    output logic [N_WAYS-1:0]     pend
);

    localparam logic [1:0] c_verde    = 2'd0;
    localparam logic [1:0] c_amarelo  = 2'd1;
    localparam logic [1:0] c_vermelho = 2'd2;
    localparam logic [1:0] c_pisca    = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_nxt_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [AW-1:0]     r_ativa;
    logic [AW-1:0]     w_nxt_ativa;
    logic [AW-1:0]     w_sel;
    logic [AW-1:0]     w_rr;
    logic [N_WAYS-1:0] r_pend;
    logic [N_WAYS-1:0] w_nxt_pend;
    logic [N_WAYS-1:0] w_req;
    logic              r_flash;
    logic              w_entra;
    logic              w_end_v;
    logic              w_end_a;
    logic              w_end_r;
    int                w_idx;

    assign w_end_v = (r_cnt == CNT_W'(T_VERDE - 1));
    assign w_end_a = (r_cnt == CNT_W'(T_AMARELO - 1));
    assign w_end_r = (r_cnt == CNT_W'(T_VERMELHO - 1));
    assign w_req   = r_pend | bt;
    assign w_rr    = (r_ativa == AW'(N_WAYS - 1)) ? '0 : r_ativa + 1'b1;

    // Descending scan: the nearest requester after r_ativa is assigned last and wins.
    always_comb begin
        w_sel = w_rr;
        w_idx = 0;
        for (int k = N_WAYS; k >= 1; k--) begin
            w_idx = (int'(r_ativa) + k) % N_WAYS;
            if (w_req[w_idx]) begin
                w_sel = AW'(w_idx);
            end
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ativa = r_ativa;
        w_entra     = 1'b0;
        case (r_state)
            c_verde: begin
                if (noturno || w_end_v) w_nxt_state = c_amarelo;
            end
            c_amarelo: begin
                if (w_end_a) w_nxt_state = noturno ? c_pisca : c_vermelho;
            end
            c_vermelho: begin
                if (noturno) begin
                    w_nxt_state = c_pisca;
                end else if (w_end_r) begin
                    w_nxt_state = c_verde;
                    w_nxt_ativa = w_sel;
                    w_entra     = 1'b1;
                end
            end
            c_pisca: begin
                if (!noturno) begin
                    w_nxt_state = c_vermelho;
                    w_nxt_ativa = AW'(N_WAYS - 1);
                end
            end
            default: w_nxt_state = c_verde;
        endcase
    end

    always_comb begin
        w_nxt_pend = r_pend | bt;
        if (r_state == c_verde) w_nxt_pend[r_ativa] = 1'b0;
        if (w_entra) w_nxt_pend[w_sel] = 1'b0;
        if (r_state == c_pisca || w_nxt_state == c_pisca) w_nxt_pend = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_verde;
            r_cnt   <= '0;
            r_ativa <= '0;
            r_pend  <= '0;
            r_flash <= 1'b1;
        end else begin
            r_state <= w_nxt_state;
            r_ativa <= w_nxt_ativa;
            r_pend  <= w_nxt_pend;
            if (w_nxt_state != r_state || (r_state == c_pisca && w_end_a)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Flash restarts "on" every time PISCA is entered.
            if (r_state != c_pisca) begin
                r_flash <= 1'b1;
            end else if (w_nxt_state == c_pisca && w_end_a) begin
                r_flash <= ~r_flash;
            end
        end
    end

    generate
        for (genvar i = 0; i < N_WAYS; i++) begin : g_lamp
            always_comb begin
                case (r_state)
                    c_verde:    luzes[3*i +: 3] = (r_ativa == AW'(i)) ? 3'b001 : 3'b100;
                    c_amarelo:  luzes[3*i +: 3] = (r_ativa == AW'(i)) ? 3'b010 : 3'b100;
                    c_vermelho: luzes[3*i +: 3] = 3'b100;
                    default:    luzes[3*i +: 3] = r_flash ? 3'b010 : 3'b000;
                endcase
            end
        end
    endgenerate

    assign ativa = r_ativa;
    assign pend  = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_semaforo_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_semaforo_n
// Description : Randomised self-checking bench for semaforo_n (three configs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_semaforo_n;

    localparam int NI      = 3;
    localparam int NW [NI] = '{2, 4, 3};
    localparam int TV [NI] = '{1, 1, 4};
    localparam int TA [NI] = '{3, 3, 2};
    localparam int TR [NI] = '{2, 2, 3};
    localparam int P_G = 0, P_Y = 1, P_R = 2, P_F = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        noturno = 1'b0;
    logic [1:0]  bt2 = '0;
    logic [3:0]  bt4 = '0;
    logic [2:0]  bt3 = '0;
    logic [5:0]  luz2;
    logic [11:0] luz4;
    logic [8:0]  luz3;
    logic [0:0]  ativa2;
    logic [1:0]  ativa4;
    logic [1:0]  ativa3;
    logic [1:0]  pend2;
    logic [3:0]  pend4;
    logic [2:0]  pend3;

    logic [23:0] d_luz  [NI];
    logic [7:0]  d_act  [NI];
    logic [7:0]  d_pend [NI];

    int ph [NI], left [NI], act [NI], mpend [NI];
    bit flash [NI];
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    semaforo_n u_dut2 (.clk(clk), .rst(rst), .bt(bt2), .noturno(noturno),
                       .luzes(luz2), .ativa(ativa2), .pend(pend2));
    semaforo_n #(.N_WAYS(4)) u_dut4 (.clk(clk), .rst(rst), .bt(bt4), .noturno(noturno),
                       .luzes(luz4), .ativa(ativa4), .pend(pend4));
    semaforo_n #(.N_WAYS(3), .CNT_W(4), .T_VERDE(TV[2]), .T_AMARELO(TA[2]), .T_VERMELHO(TR[2]))
        u_dut3 (.clk(clk), .rst(rst), .bt(bt3), .noturno(noturno),
                .luzes(luz3), .ativa(ativa3), .pend(pend3));

    always_comb begin
        d_luz[0] = 24'(luz2);  d_act[0] = 8'(ativa2);  d_pend[0] = 8'(pend2);
        d_luz[1] = 24'(luz4);  d_act[1] = 8'(ativa4);  d_pend[1] = 8'(pend4);
        d_luz[2] = 24'(luz3);  d_act[2] = 8'(ativa3);  d_pend[2] = 8'(pend3);
    end

    // Reference model: phase name plus cycles remaining, request set as an int mask.
    task automatic model_reset();
        for (int m = 0; m < NI; m++) begin
            ph[m] = P_G; left[m] = TV[m]; act[m] = 0; mpend[m] = 0; flash[m] = 1'b1;
        end
    endtask

    function automatic int pick(input int m, input int req);
        for (int k = 1; k <= NW[m]; k++) begin
            if (((req >> ((act[m] + k) % NW[m])) & 1) != 0) return (act[m] + k) % NW[m];
        end
        return (act[m] + 1) % NW[m];
    endfunction

    task automatic model_step(input int m, input int b, input bit noc);
        int np, req, nph;
        req = mpend[m] | b;
        np  = mpend[m] | b;
        nph = ph[m];
        if (ph[m] == P_G) np &= ~(1 << act[m]);
        case (ph[m])
            P_G: if (noc || left[m] == 1) begin nph = P_Y; left[m] = TA[m]; end
                 else left[m]--;
            P_Y: if (left[m] == 1) begin
                     nph = noc ? P_F : P_R; left[m] = noc ? TA[m] : TR[m]; flash[m] = 1'b1;
                 end else left[m]--;
            P_R: if (noc) begin nph = P_F; left[m] = TA[m]; flash[m] = 1'b1; end
                 else if (left[m] == 1) begin
                     nph = P_G; left[m] = TV[m]; act[m] = pick(m, req); np &= ~(1 << act[m]);
                 end else left[m]--;
            default: if (!noc) begin nph = P_R; left[m] = TR[m]; act[m] = NW[m] - 1; end
                 else if (left[m] == 1) begin flash[m] = !flash[m]; left[m] = TA[m]; end
                 else left[m]--;
        endcase
        if (ph[m] == P_F || nph == P_F) np = 0;
        ph[m] = nph;
        mpend[m] = np;
    endtask

    function automatic logic [23:0] exp_luz(input int m);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < NW[m]; i++) begin
            case (ph[m])
                P_G:     r[3*i +: 3] = (i == act[m]) ? 3'b001 : 3'b100;
                P_Y:     r[3*i +: 3] = (i == act[m]) ? 3'b010 : 3'b100;
                P_R:     r[3*i +: 3] = 3'b100;
                default: r[3*i +: 3] = flash[m] ? 3'b010 : 3'b000;
            endcase
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_step(0, int'(bt2), noturno);
            model_step(1, int'(bt4), noturno);
            model_step(2, int'(bt3), noturno);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; noturno = 1'b0; bt2 = '0; bt4 = '0; bt3 = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        nvec++; if (luz2 !== 6'b100001) begin nerr++; $display("FAIL reset_luz2 got %b exp 100001", luz2); end
        nvec++; if (luz4 !== 12'b100100100001) begin nerr++; $display("FAIL reset_luz4 got %b exp 100100100001", luz4); end
        nvec++; if (ativa4 !== 2'd0 || pend4 !== 4'd0) begin nerr++; $display("FAIL reset_regs got ativa=%0d pend=%b exp 0/0000", ativa4, pend4); end
        do_reset();
    endtask

    task automatic test_default_cycle();
        logic [5:0] e;
        int pos, way, p;
        do_reset();
        for (int c = 1; c <= 24; c++) begin
            pos = (c - 1) % 12; way = pos / 6; p = pos % 6;
            if (p == 0)      e = (way == 0) ? 6'b100001 : 6'b001100;
            else if (p <= 3) e = (way == 0) ? 6'b100010 : 6'b010100;
            else             e = 6'b100100;
            nvec++; if (luz2 !== e) begin nerr++; $display("FAIL cycle%0d_luz2 got %b exp %b", c, luz2, e); end
            tick();
        end
    endtask

    task automatic test_skip();
        do_reset();
        bt4 = 4'b0100;
        tick();
        bt4 = '0;
        nvec++; if (pend4 !== 4'b0100) begin nerr++; $display("FAIL skip_latch got %b exp 0100", pend4); end
        repeat (5) tick();
        nvec++; if (ativa4 !== 2'd2 || pend4 !== 4'b0000) begin nerr++; $display("FAIL skip_sel got ativa=%0d pend=%b exp 2/0000", ativa4, pend4); end
        nvec++; if (luz4 !== 12'b100001100100) begin nerr++; $display("FAIL skip_luz got %b exp 100001100100", luz4); end
    endtask

    task automatic test_pair();
        do_reset();
        bt4 = 4'b1010;
        tick();
        bt4 = '0;
        nvec++; if (pend4 !== 4'b1010) begin nerr++; $display("FAIL pair_latch got %b exp 1010", pend4); end
        repeat (5) tick();
        nvec++; if (ativa4 !== 2'd1 || pend4 !== 4'b1000) begin nerr++; $display("FAIL pair_first got %0d/%b exp 1/1000", ativa4, pend4); end
        repeat (6) tick();
        nvec++; if (ativa4 !== 2'd3 || pend4 !== 4'b0000) begin nerr++; $display("FAIL pair_second got %0d/%b exp 3/0000", ativa4, pend4); end
        repeat (6) tick();
        nvec++; if (ativa4 !== 2'd0) begin nerr++; $display("FAIL pair_rr got %0d exp 0", ativa4); end
    endtask

    task automatic test_night();
        logic [5:0] ne [13] = '{6'b100010, 6'b100010, 6'b100010, 6'b010010, 6'b010010,
                                6'b010010, 6'b000000, 6'b000000, 6'b000000, 6'b010010,
                                6'b100100, 6'b100100, 6'b100001};
        do_reset();
        noturno = 1'b1;
        for (int t = 0; t < 13; t++) begin
            if (t == 10) noturno = 1'b0;
            bt2 = (t >= 4 && t < 10) ? 2'($urandom) : '0;
            bt4 = (t >= 4 && t < 10) ? 4'($urandom) : '0;
            bt3 = (t >= 4 && t < 10) ? 3'($urandom) : '0;
            tick();
            nvec++; if (luz2 !== ne[t]) begin nerr++; $display("FAIL night%0d_luz2 got %b exp %b", t, luz2, ne[t]); end
            if (t >= 3 && t < 10) begin
                nvec++; if (pend2 !== 2'b00) begin nerr++; $display("FAIL night%0d_pend2 got %b exp 00", t, pend2); end
            end
            for (int m = 1; m < NI; m++) begin
                nvec++; if (d_luz[m] !== exp_luz(m) || d_pend[m] !== 8'(mpend[m]))
                    begin nerr++; $display("FAIL night%0d_dut%0d got %h/%h exp %h/%h", t, m, d_luz[m], d_pend[m], exp_luz(m), mpend[m]); end
            end
        end
        bt2 = '0; bt4 = '0; bt3 = '0;
        nvec++; if (ativa4 !== 2'd0) begin nerr++; $display("FAIL night_exit_way got %0d exp 0", ativa4); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        n = 0;
        while (!(ph[0] == P_Y && act[0] == 1) && n < 20) begin tick(); n++; end
        nvec++; if (n >= 20) begin nerr++; $display("FAIL rstmid_reach got %0d cycles exp <20", n); end
        #2 rst = 1'b1;
        #1;
        nvec++; if (luz2 !== 6'b100001 || ativa2 !== 1'b0 || pend2 !== 2'b00)
            begin nerr++; $display("FAIL rstmid_async got %b/%0d/%b exp 100001/0/00", luz2, ativa2, pend2); end
        model_reset();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            nvec++; if (luz2 !== exp_luz(0)) begin nerr++; $display("FAIL rstmid%0d_luz2 got %b exp %b", c, luz2, exp_luz(0)); end
        end
    endtask

    task automatic test_held();
        do_reset();
        bt4 = 4'b0100;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1 || c == 8) begin
                nvec++; if (pend4 !== 4'b0100) begin nerr++; $display("FAIL held%0d_pend got %b exp 0100", c, pend4); end
            end
            if (c == 6 || c == 7) begin
                nvec++; if (pend4 !== 4'b0000) begin nerr++; $display("FAIL held%0d_pend got %b exp 0000", c, pend4); end
            end
            if (c == 6 || c == 12) begin
                nvec++; if (ativa4 !== 2'd2) begin nerr++; $display("FAIL held%0d_way got %0d exp 2", c, ativa4); end
            end
        end
        bt4 = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bt2 = ($urandom_range(0, 3) == 0) ? 2'($urandom) : '0;
            bt4 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
            bt3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : '0;
            if ($urandom_range(0, 39) == 0) noturno = !noturno;
            rst = ($urandom_range(0, 199) == 0);
            tick();
            for (int m = 0; m < NI; m++) begin
                nvec++; if (d_luz[m] !== exp_luz(m) || d_act[m] !== 8'(act[m]) || d_pend[m] !== 8'(mpend[m]))
                    begin nerr++; $display("FAIL rand%0d_dut%0d got luz=%h ativa=%0d pend=%h exp luz=%h ativa=%0d pend=%h",
                        c, m, d_luz[m], d_act[m], d_pend[m], exp_luz(m), act[m], mpend[m]); end
            end
        end
        rst = 1'b0; noturno = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_default_cycle();
        test_skip();
        test_pair();
        test_night();
        test_reset_mid();
        test_held();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
